// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [4:0]  HALT_OP_DEF = 5'b00000;
   localparam logic [15:0] PC_INC      = 16'd2;

   typedef struct packed {
      logic [15:0] inst;
      logic [15:0] pc;
   } qentry_t;

   function automatic logic is_op(input logic [15:0] inst, input logic [4:0] op);
      return inst[15:11] == op;
   endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Two-entry instruction queue holding {inst, pc}; flush empties it at the next edge.
module fetch_unit_queue
   import fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_push,
   input  logic [15:0] i_inst,
   input  logic [15:0] i_pc,
   input  logic        i_pop,
   input  logic        i_flush,
   output logic        o_valid,
   output logic [15:0] o_inst,
   output logic [15:0] o_pc,
   output logic [1:0]  o_count,
   output logic        o_ovf
);

   qentry_t     r_mem [2];
   logic        r_wptr;
   logic        r_rptr;
   logic [1:0]  r_count;
   logic        w_push_ok;
   logic        w_pop_ok;

   assign w_push_ok = i_push && (r_count != 2'd2) && !i_flush;
   assign w_pop_ok  = i_pop  && (r_count != 2'd0) && !i_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else if (i_flush) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push_ok) r_wptr <= ~r_wptr;
         if (w_pop_ok)  r_rptr <= ~r_rptr;
         r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
      end
   end

   // Payload storage carries no reset; occupancy is tracked by the control regs above.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= '{inst: i_inst, pc: i_pc};
   end

   assign o_valid = (r_count != 2'd0);
   assign o_inst  = r_mem[r_rptr].inst;
   assign o_pc    = r_mem[r_rptr].pc;
   assign o_count = r_count;
   assign o_ovf   = i_push && (r_count == 2'd2) && !i_flush;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues one imem request at a time, queues results for decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [4:0]  HALT_OP  = HALT_OP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_valid,
   input  logic [15:0] imem_data,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        inst_valid,
   output logic [15:0] inst,
   output logic [15:0] inst_pc,
   output logic [15:0] inst_pc_inc,
   input  logic        inst_ready,
   output logic        halted,
   output logic        err
);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_pc;
   logic        r_outstanding;
   logic        r_halted;
   logic        r_err;

   logic        w_redir, w_redir_ok, w_redir_bad;
   logic        w_accept, w_resp, w_push, w_pop, w_halt_pop, w_spurious;
   logic        w_q_valid, w_q_ovf;
   logic [15:0] w_q_inst, w_q_pc;
   logic [1:0]  w_q_count;

   assign w_redir     = redirect && !r_halted;
   assign w_redir_ok  = w_redir && !redirect_pc[0];
   assign w_redir_bad = w_redir &&  redirect_pc[0];
   assign w_accept    = imem_req && imem_ready;
   assign w_resp      = imem_valid && !r_halted;
   assign w_push      = (r_state == S_WAIT) && w_resp && !w_redir;
   assign w_spurious  = w_resp && !r_outstanding;
   assign w_pop       = inst_valid && inst_ready;
   assign w_halt_pop  = w_pop && is_op(w_q_inst, HALT_OP);

   // In S_WAIT the PC has already advanced past the request being returned.
   fetch_unit_queue u_queue (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (w_push),
      .i_inst  (imem_data),
      .i_pc    (r_pc - PC_INC),
      .i_pop   (w_pop),
      .i_flush (w_redir),
      .o_valid (w_q_valid),
      .o_inst  (w_q_inst),
      .o_pc    (w_q_pc),
      .o_count (w_q_count),
      .o_ovf   (w_q_ovf)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_REQ;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_REQ:   if (w_accept)   w_next = S_WAIT;
         S_WAIT:  if (imem_valid) w_next = is_op(imem_data, HALT_OP) ? S_HALT : S_REQ;
         S_DRAIN: if (imem_valid) w_next = S_REQ;
         default: w_next = S_HALT;
      endcase
      // A squashed response still in flight must be drained before refetching.
      if (w_redir_ok)  w_next = (r_outstanding && !imem_valid) ? S_DRAIN : S_REQ;
      if (w_redir_bad) w_next = S_HALT;
      if (w_halt_pop || r_halted) w_next = S_HALT;
   end

   always_comb begin
      imem_req = rst && (r_state == S_REQ) && (w_q_count <= 2'd1) && !redirect && !r_halted;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc          <= RESET_PC;
         r_outstanding <= 1'b0;
         r_halted      <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         if (w_redir_ok)    r_pc <= redirect_pc;
         else if (w_accept) r_pc <= r_pc + PC_INC;
         if (w_accept)        r_outstanding <= 1'b1;
         else if (imem_valid) r_outstanding <= 1'b0;
         r_halted <= r_halted | w_halt_pop;
         r_err    <= r_err | w_redir_bad | w_spurious | w_q_ovf;
      end
   end

   assign imem_addr   = r_pc;
   assign inst_valid  = w_q_valid && !r_halted;
   assign inst        = w_q_inst;
   assign inst_pc     = w_q_pc;
   assign inst_pc_inc = w_q_pc + PC_INC;
   assign halted      = r_halted;
   assign err         = r_err;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of decode/execute.
- Owns the architectural PC and issues one request at a time to an instruction memory that may stall.
- Buffers returned instructions in a 2-entry queue and hands them to decode with a valid/ready handshake.
- Handles branch/jump redirects from execute, stops fetching on HALT and flags protocol errors.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
HALT_OP, 5'b00000, opcode (inst[15:11]) that stops fetching

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
imem_req  out  1  fetch request valid
imem_addr  out  16  fetch address (current PC)
imem_ready  in  1  memory accepts request this cycle (imem_req & imem_ready = accept)
imem_valid  in  1  read data returned, in order, at least 1 cycle after accept
imem_data  in  16  returned instruction
redirect  in  1  execute requests PC change
redirect_pc  in  16  new PC
inst_valid  out  1  queue head valid
inst  out  16  queue head instruction
inst_pc  out  16  PC of queue head
inst_pc_inc  out  16  inst_pc + 2, wraps modulo 2^16
inst_ready  in  1  decode consumes head (inst_valid & inst_ready = pop)
halted  out  1  HALT has been consumed by decode; sticky
err  out  1  sticky protocol/alignment error

Behaviour:
- Reset (rst=0, asynchronous): PC=RESET_PC, queue empty, state=S_REQ, outstanding=0, inst_valid=0, halted=0, err=0. imem_req is forced to 0 while rst=0.
- Outputs inst, inst_pc and inst_pc_inc are X-don't-care when inst_valid=0. The bench checks them only when inst_valid=1.
- FSM states: S_REQ, S_WAIT, S_DRAIN, S_HALT.
- S_REQ:
  - imem_req=1 iff queue count<=1 and no redirect this cycle. imem_addr=PC.
  - On accept: PC<=PC+2 (16'hFFFE wraps to 16'h0000, not an error); go to S_WAIT.
- S_WAIT:
  - imem_req=0.
  - On imem_valid: enqueue {imem_data, PC of request}.
  - If imem_data[15:11]==HALT_OP, go to S_HALT; otherwise go to S_REQ.
  - Space is guaranteed: the request was issued with count<=1, and the count only decreases while waiting.
- S_DRAIN:
  - A squashed request is in flight. imem_req=0.
  - Next imem_valid is discarded (not enqueued), then go to S_REQ.
- S_HALT:
  - No requests issued.
  - Queue keeps draining to decode; the HALT instruction itself is delivered.
  - When decode pops an instruction with HALT_OP, halted<=1 next cycle.
- Latency: imem_valid in cycle t gives inst_valid=1 in cycle t+1 (registered queue, no bypass).
- Redirect (redirect=1, halted=0, redirect_pc[0]=0), applied at the clock edge:
  - Queue flushed; inst_valid=0 next cycle; a pop in the same cycle is still honoured.
  - PC<=redirect_pc.
  - From S_WAIT, with no imem_valid the same cycle: go to S_DRAIN.
  - From S_WAIT, with imem_valid the same cycle: data discarded; go to S_REQ.
  - From S_REQ or S_HALT: go to S_REQ. Redirect cancels a pending HALT.
  - From S_DRAIN: stay in S_DRAIN; PC updated.
  - Redirect has priority over enqueue and over request issue in the same cycle.
- Misaligned redirect_pc[0]=1:
  - err<=1.
  - Queue flushed, PC unchanged.
  - Go to S_HALT without delivering anything further; halted stays 0.
- imem_valid while outstanding=0 (state S_REQ or S_HALT with no in-flight request): err<=1, data ignored, state unchanged.
- After halted=1: redirect, imem_valid and inst_ready are ignored; inst_valid=0. Only reset exits.
- Reset asserted mid-request: all state is cleared immediately. The memory side must drop any in-flight response; a response arriving after rst deasserts sets err.
- Queue: 2 entries, each {inst[15:0], pc[15:0]}. Pointers are 1 bit, plus a 2-bit count. Simultaneous push and pop at count=2 cannot occur by construction; push at count=2 sets err (assertion-level safety).

Decomposition:
- fetch_defs.v (shared include): state encodings S_REQ=2'd0, S_WAIT=2'd1, S_DRAIN=2'd2, S_HALT=2'd3; HALT_OP; PC increment constant 16'd2.
- Sub-module fetch_queue: 2-entry synchronous FIFO with push, pop, flush, count, head outputs and overflow error.
- fetch_unit instantiates fetch_queue and holds the FSM, PC and outstanding flag.

Test Plan:
- Reset, then memory always ready with 1-cycle latency, returning 16'h4000 (non-HALT) at 0, 2, 4; inst_ready=1 → imem_addr sequence 0000, 0002, 0004; inst_valid with inst_pc 0000, 0002, 0004 and inst_pc_inc 0002, 0004, 0006.
- inst_ready=0 held for 6 cycles → exactly 2 entries queued, imem_req drops to 0. Releasing inst_ready → in-order delivery, with PCs 0000 then 0002 first.
- redirect=1 to 16'h0100 while in S_WAIT → next response discarded, next imem_addr=0100, first delivered inst_pc=0100.
- Memory returns 16'h0000 at PC 0006 → no further imem_req; after decode pops it, halted=1. Later redirect to 16'h0200 is ignored.
- HALT enqueued, then redirect to 16'h0040 before it is popped → halt cancelled, fetch resumes at 0040, halted stays 0.
- Redirect to 16'h0101 → err=1, no further requests, inst_valid=0. Separately, a spurious imem_valid in S_REQ → err=1.
